// File: rtl/risc_v_mike_lsu_pkg.sv
// Shared LSU types, memory-map anchors and funct3 decode helpers.
// Region limits that depend on memory sizes are derived in the top from its parameters.
`ifndef DATA_MEM_DEPTH
`define DATA_MEM_DEPTH 1024
`endif
`ifndef MMIO_MEM_SIZE
`define MMIO_MEM_SIZE 16
`endif

package risc_v_mike_lsu_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_ACCESS,
        LSU_CAPTURE,
        LSU_RESP
    } t_lsu_state;

    typedef enum logic [1:0] {
        REGION_DATA,
        REGION_STACK,
        REGION_MMIO,
        REGION_NONE
    } t_mem_region;

    localparam logic [2:0] LSU_F3_B  = 3'b000;
    localparam logic [2:0] LSU_F3_H  = 3'b001;
    localparam logic [2:0] LSU_F3_W  = 3'b010;
    localparam logic [2:0] LSU_F3_BU = 3'b100;
    localparam logic [2:0] LSU_F3_HU = 3'b101;

    localparam logic [31:0] DATA_LOWER  = 32'h1001_0000;
    localparam logic [31:0] MMIO_LOWER  = 32'h1001_0024;
    localparam logic [31:0] STACK_UPPER = 32'h7FFF_EFFC;

    function automatic logic lsu_f3_legal(input logic is_store, input logic [2:0] funct3);
        if (is_store) begin
            return funct3 inside {LSU_F3_B, LSU_F3_H, LSU_F3_W};
        end
        return funct3 inside {LSU_F3_B, LSU_F3_H, LSU_F3_W, LSU_F3_BU, LSU_F3_HU};
    endfunction

    function automatic logic lsu_aligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b01:   return ~addr_lo[0];
            2'b10:   return addr_lo == 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/risc_v_mike_lsu_align.sv
// Store lane replication / byte-enable generation and load lane extraction / extension.
// Purely combinational; the top chooses which request fields feed it.
module risc_v_mike_lsu_align
    import risc_v_mike_lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_st_data,
    input  logic [31:0] i_ld_word,
    output logic [31:0] o_st_wdata,
    output logic [3:0]  o_st_be,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_st_wdata = i_st_data;
        o_st_be    = 4'b1111;
        case (i_funct3[1:0])
            2'b00: begin
                o_st_wdata = {4{i_st_data[7:0]}};
                o_st_be    = 4'b0001 << i_addr_lo;
            end
            2'b01: begin
                o_st_wdata = {2{i_st_data[15:0]}};
                o_st_be    = 4'b0011 << i_addr_lo;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (i_addr_lo)
            2'b00:   w_byte = i_ld_word[7:0];
            2'b01:   w_byte = i_ld_word[15:8];
            2'b10:   w_byte = i_ld_word[23:16];
            default: w_byte = i_ld_word[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_ld_word[31:16] : i_ld_word[15:0];
    end

    always_comb begin
        o_ld_data = '0;
        case (i_funct3)
            LSU_F3_B:  o_ld_data = {{24{w_byte[7]}}, w_byte};
            LSU_F3_H:  o_ld_data = {{16{w_half[15]}}, w_half};
            LSU_F3_W:  o_ld_data = i_ld_word;
            LSU_F3_BU: o_ld_data = {24'd0, w_byte};
            LSU_F3_HU: o_ld_data = {16'd0, w_half};
            default:   o_ld_data = '0;
        endcase
    end

endmodule

// File: rtl/risc_v_mike_lsu.sv
// Load/store unit: accepts one request per handshake, decodes stack/data/MMIO region,
// issues one registered memory strobe and returns extended load data or an error.
module risc_v_mike_lsu
    import risc_v_mike_lsu_pkg::*;
#(
    parameter int unsigned DATA_DEPTH = `DATA_MEM_DEPTH,
    parameter int unsigned MMIO_SIZE  = `MMIO_MEM_SIZE
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_we,
    input  logic [2:0]                      req_funct3,
    input  logic [31:0]                     req_addr,
    input  logic [31:0]                     req_wdata,
    output logic                            rsp_valid,
    output logic [31:0]                     rsp_rdata,
    output logic                            rsp_err,
    output logic                            dmem_en,
    output logic                            dmem_we,
    output logic [3:0]                      dmem_be,
    output logic [$clog2(DATA_DEPTH)-3:0]   dmem_addr,
    output logic [31:0]                     dmem_wdata,
    input  logic [31:0]                     dmem_rdata,
    output logic                            mmio_en,
    output logic                            mmio_we,
    output logic [3:0]                      mmio_be,
    output logic [$clog2(MMIO_SIZE)-3:0]    mmio_addr,
    output logic [31:0]                     mmio_wdata,
    input  logic [31:0]                     mmio_rdata
);

    localparam int unsigned DAW = $clog2(DATA_DEPTH) - 2;
    localparam int unsigned MAW = $clog2(MMIO_SIZE) - 2;

    localparam logic [31:0] HALF_DEPTH                = 32'(DATA_DEPTH / 2);
    localparam logic [31:0] MEM_MAP_MMIO_UPPER_LIMIT  = MMIO_LOWER + 32'(MMIO_SIZE);
    localparam logic [31:0] MEM_MAP_DATA_UPPER_LIMIT  = DATA_LOWER + HALF_DEPTH - 32'd1;
    localparam logic [31:0] MEM_MAP_STACK_LOWER_LIMIT = STACK_UPPER - HALF_DEPTH;
    localparam logic [31:0] STACK_PHYS_BASE           = MEM_MAP_STACK_LOWER_LIMIT + 32'd4;

    t_lsu_state  r_state, w_state_next;
    t_mem_region w_region, r_region;
    logic [31:0] w_phys;
    logic        w_err;

    logic        r_we;
    logic [2:0]  r_funct3;
    logic [1:0]  r_addr_lo;
    logic        r_req_ready, r_rsp_valid, r_rsp_err;
    logic [31:0] r_rsp_rdata;

    logic            r_dmem_en, r_dmem_we;
    logic [3:0]      r_dmem_be;
    logic [DAW-1:0]  r_dmem_addr;
    logic [31:0]     r_dmem_wdata;
    logic            r_mmio_en, r_mmio_we;
    logic [3:0]      r_mmio_be;
    logic [MAW-1:0]  r_mmio_addr;
    logic [31:0]     r_mmio_wdata;

    logic [2:0]  w_al_funct3;
    logic [1:0]  w_al_addr_lo;
    logic [31:0] w_ld_word, w_st_wdata, w_ld_data;
    logic [3:0]  w_st_be;
    logic        w_unused_phys;

    // MMIO is tested first so it wins where it overlaps the data region.
    always_comb begin
        w_region = REGION_NONE;
        w_phys   = '0;
        if (req_addr >= MMIO_LOWER && req_addr < MEM_MAP_MMIO_UPPER_LIMIT) begin
            w_region = REGION_MMIO;
            w_phys   = req_addr - MMIO_LOWER;
        end else if (req_addr >= DATA_LOWER && req_addr <= MEM_MAP_DATA_UPPER_LIMIT) begin
            w_region = REGION_DATA;
            w_phys   = req_addr - DATA_LOWER;
        end else if (req_addr > MEM_MAP_STACK_LOWER_LIMIT &&
                     req_addr <= STACK_UPPER + 32'd3) begin
            w_region = REGION_STACK;
            w_phys   = req_addr - STACK_PHYS_BASE + HALF_DEPTH;
        end
    end

    assign w_err = (w_region == REGION_NONE) || !lsu_f3_legal(req_we, req_funct3) ||
                   !lsu_aligned(req_funct3, req_addr[1:0]);

    assign w_unused_phys = ^{w_phys[31:DAW+2], w_phys[1:0]};

    // Store formatting uses the live request at accept; load extraction uses the held copy.
    assign w_al_funct3  = (r_state == LSU_IDLE) ? req_funct3    : r_funct3;
    assign w_al_addr_lo = (r_state == LSU_IDLE) ? req_addr[1:0] : r_addr_lo;
    assign w_ld_word    = (r_region == REGION_MMIO) ? mmio_rdata : dmem_rdata;

    risc_v_mike_lsu_align u_align (
        .i_funct3   (w_al_funct3),
        .i_addr_lo  (w_al_addr_lo),
        .i_st_data  (req_wdata),
        .i_ld_word  (w_ld_word),
        .o_st_wdata (w_st_wdata),
        .o_st_be    (w_st_be),
        .o_ld_data  (w_ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LSU_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            LSU_IDLE:    if (req_valid) w_state_next = w_err ? LSU_RESP : LSU_ACCESS;
            LSU_ACCESS:  w_state_next = r_we ? LSU_RESP : LSU_CAPTURE;
            LSU_CAPTURE: w_state_next = LSU_RESP;
            LSU_RESP:    w_state_next = LSU_IDLE;
            default:     w_state_next = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we         <= 1'b0;
            r_funct3     <= '0;
            r_addr_lo    <= '0;
            r_region     <= REGION_DATA;
            r_req_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rsp_rdata  <= '0;
            r_dmem_en    <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_be    <= '0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_mmio_en    <= 1'b0;
            r_mmio_we    <= 1'b0;
            r_mmio_be    <= '0;
            r_mmio_addr  <= '0;
            r_mmio_wdata <= '0;
        end else begin
            r_req_ready  <= (w_state_next == LSU_IDLE);
            r_rsp_valid  <= (w_state_next == LSU_RESP);
            r_dmem_en    <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_be    <= '0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_mmio_en    <= 1'b0;
            r_mmio_we    <= 1'b0;
            r_mmio_be    <= '0;
            r_mmio_addr  <= '0;
            r_mmio_wdata <= '0;
            unique case (r_state)
                LSU_IDLE: begin
                    if (req_valid) begin
                        r_we        <= req_we;
                        r_funct3    <= req_funct3;
                        r_addr_lo   <= req_addr[1:0];
                        r_region    <= w_region;
                        r_rsp_err   <= w_err;
                        r_rsp_rdata <= '0;
                        if (!w_err && w_region == REGION_MMIO) begin
                            r_mmio_en    <= 1'b1;
                            r_mmio_we    <= req_we;
                            r_mmio_be    <= w_st_be;
                            r_mmio_addr  <= w_phys[MAW+1:2];
                            r_mmio_wdata <= req_we ? w_st_wdata : '0;
                        end else if (!w_err) begin
                            r_dmem_en    <= 1'b1;
                            r_dmem_we    <= req_we;
                            r_dmem_be    <= w_st_be;
                            r_dmem_addr  <= w_phys[DAW+1:2];
                            r_dmem_wdata <= req_we ? w_st_wdata : '0;
                        end
                    end
                end
                LSU_ACCESS: ;
                LSU_CAPTURE: r_rsp_rdata <= w_ld_data;
                LSU_RESP: begin
                    r_rsp_rdata <= '0;
                    r_rsp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_err    = r_rsp_err;
    assign dmem_en    = r_dmem_en;
    assign dmem_we    = r_dmem_we;
    assign dmem_be    = r_dmem_be;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_wdata = r_dmem_wdata;
    assign mmio_en    = r_mmio_en;
    assign mmio_we    = r_mmio_we;
    assign mmio_be    = r_mmio_be;
    assign mmio_addr  = r_mmio_addr;
    assign mmio_wdata = r_mmio_wdata;

endmodule

// File: tb/tb_risc_v_mike_lsu.sv
// Bench for risc_v_mike_lsu: directed vector table, random traffic against a byte-level
// reference model, and an asynchronous reset abort sequence.
module tb_risc_v_mike_lsu;

    localparam int unsigned DATA_DEPTH = 1024;
    localparam int unsigned MMIO_SIZE  = 16;
    localparam logic [31:0] A_DATA     = 32'h1001_0000;
    localparam logic [31:0] A_MMIO     = 32'h1001_0024;
    localparam logic [31:0] A_STK_TOP  = 32'h7FFF_EFFC;
    localparam logic [31:0] A_STK_LIM  = A_STK_TOP - 32'd512;
    localparam int          NV         = 23;

    logic        clk, rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        dmem_en, dmem_we, mmio_en, mmio_we;
    logic [3:0]  dmem_be, mmio_be;
    logic [7:0]  dmem_addr;
    logic [1:0]  mmio_addr;
    logic [31:0] dmem_wdata, dmem_rdata, mmio_wdata, mmio_rdata;

    typedef struct {
        bit        we;
        bit [2:0]  f3;
        bit [31:0] addr;
        bit [31:0] wd;
        bit        err;
        bit        mmio;
        bit [31:0] word;
        bit [3:0]  be;
        bit [31:0] ewd;
        bit [31:0] rd;
    } vec_t;

    bit [31:0] dram [256];
    bit [31:0] mram [4];
    bit [7:0]  ref_d [1024];
    bit [7:0]  ref_m [16];
    vec_t      tbl [NV];
    int        n_checks, n_err;

    risc_v_mike_lsu #(
        .DATA_DEPTH (DATA_DEPTH),
        .MMIO_SIZE  (MMIO_SIZE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .dmem_en    (dmem_en),
        .dmem_we    (dmem_we),
        .dmem_be    (dmem_be),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .mmio_en    (mmio_en),
        .mmio_we    (mmio_we),
        .mmio_be    (mmio_be),
        .mmio_addr  (mmio_addr),
        .mmio_wdata (mmio_wdata),
        .mmio_rdata (mmio_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Word RAMs the DUT talks to: byte-enabled writes, read data one cycle after en.
    always @(posedge clk) begin
        if (dmem_en) begin
            for (int i = 0; i < 4; i++)
                if (dmem_we && dmem_be[i]) dram[dmem_addr][8*i +: 8] <= dmem_wdata[8*i +: 8];
            dmem_rdata <= dram[dmem_addr];
        end
        if (mmio_en) begin
            for (int i = 0; i < 4; i++)
                if (mmio_we && mmio_be[i]) mram[mmio_addr][8*i +: 8] <= mmio_wdata[8*i +: 8];
            mmio_rdata <= mram[mmio_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model on a byte-addressed view of memory; updates it on stores.
    task automatic model(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                         input bit [31:0] wd, output vec_t v);
        int unsigned size, off;
        bit [31:0]   phys;
        bit          legal, mapped, is_mmio;
        longint      val;
        v.we = we; v.f3 = f3; v.addr = addr; v.wd = wd;
        v.err = 1'b0; v.mmio = 1'b0; v.word = '0; v.be = '0; v.ewd = '0; v.rd = '0;
        size   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal  = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        off    = addr % 4;
        mapped = 1'b1;
        is_mmio = 1'b0;
        phys   = '0;
        if (addr >= A_MMIO && addr < A_MMIO + MMIO_SIZE) begin
            is_mmio = 1'b1;
            phys = addr - A_MMIO;
        end else if (addr >= A_DATA && addr < A_DATA + DATA_DEPTH / 2) begin
            phys = addr - A_DATA;
        end else if (addr > A_STK_LIM && addr <= A_STK_TOP + 3) begin
            phys = addr - (A_STK_LIM + 4) + DATA_DEPTH / 2;
        end else begin
            mapped = 1'b0;
        end
        v.err = !legal || !mapped || (addr % size != 0);
        if (v.err) return;
        v.mmio = is_mmio;
        v.word = phys / 4;
        v.be   = 4'(((1 << size) - 1) << off);
        if (we) begin
            v.ewd = (size == 1) ? {4{wd[7:0]}} : (size == 2) ? {2{wd[15:0]}} : wd;
            for (int i = 0; i < int'(size); i++) begin
                if (is_mmio) ref_m[phys + i] = wd[8*i +: 8];
                else         ref_d[phys + i] = wd[8*i +: 8];
            end
        end else begin
            val = 0;
            for (int i = 0; i < int'(size); i++)
                val += longint'(is_mmio ? ref_m[phys + i] : ref_d[phys + i]) << (8 * i);
            if (!f3[2] && size < 4 && val >= (longint'(1) << (8 * size - 1)))
                val -= longint'(1) << (8 * size);
            v.rd = 32'(val);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        chk({tag, " ready"}, 32'(req_ready), 32'd1);
        chk({tag, " idle_rsp"}, 32'(rsp_valid), 32'd0);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wd;
        @(negedge clk);
        req_valid = 1'b0;
        if (v.err) begin
            chk({tag, " err_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, " err_flag"}, 32'(rsp_err), 32'd1);
            chk({tag, " err_rdata"}, rsp_rdata, 32'd0);
            chk({tag, " err_no_en"}, 32'({dmem_en, mmio_en}), 32'd0);
        end else begin
            chk({tag, " dmem_en"}, 32'(dmem_en), 32'(!v.mmio));
            chk({tag, " mmio_en"}, 32'(mmio_en), 32'(v.mmio));
            chk({tag, " early_rsp"}, 32'(rsp_valid), 32'd0);
            chk({tag, " addr"}, v.mmio ? 32'(mmio_addr) : 32'(dmem_addr), v.word);
            chk({tag, " we"}, v.mmio ? 32'(mmio_we) : 32'(dmem_we), 32'(v.we));
            if (v.we) begin
                chk({tag, " be"}, v.mmio ? 32'(mmio_be) : 32'(dmem_be), 32'(v.be));
                chk({tag, " wdata"}, v.mmio ? mmio_wdata : dmem_wdata, v.ewd);
            end
            @(negedge clk);
            chk({tag, " en_drop"}, 32'({dmem_en, mmio_en}), 32'd0);
            if (v.we) begin
                chk({tag, " st_valid"}, 32'(rsp_valid), 32'd1);
                chk({tag, " st_err"}, 32'(rsp_err), 32'd0);
                chk({tag, " st_rdata"}, rsp_rdata, 32'd0);
            end else begin
                chk({tag, " ld_wait"}, 32'(rsp_valid), 32'd0);
                @(negedge clk);
                chk({tag, " ld_valid"}, 32'(rsp_valid), 32'd1);
                chk({tag, " ld_err"}, 32'(rsp_err), 32'd0);
                chk({tag, " ld_rdata"}, rsp_rdata, v.rd);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, want $finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v, scratch;
        bit   seen;
        n_checks = 0;
        n_err    = 0;
        //         we    f3    addr          wd            err   mmio  word    be    ewd           rd
        tbl[0]  = '{1'b1, 3'd2, 32'h10010000, 32'hDEADBEEF, 1'b0, 1'b0, 32'h00, 4'hF, 32'hDEADBEEF, 32'h0};
        tbl[1]  = '{1'b1, 3'd2, 32'h10010000, 32'h80FF0011, 1'b0, 1'b0, 32'h00, 4'hF, 32'h80FF0011, 32'h0};
        tbl[2]  = '{1'b0, 3'd0, 32'h10010003, 32'h0,        1'b0, 1'b0, 32'h00, 4'h0, 32'h0, 32'hFFFFFF80};
        tbl[3]  = '{1'b0, 3'd4, 32'h10010003, 32'h0,        1'b0, 1'b0, 32'h00, 4'h0, 32'h0, 32'h00000080};
        tbl[4]  = '{1'b1, 3'd1, 32'h7FFFEFFE, 32'h1234ABCD, 1'b0, 1'b0, 32'hFF, 4'hC, 32'hABCDABCD, 32'h0};
        tbl[5]  = '{1'b0, 3'd1, 32'h7FFFEFFE, 32'h0,        1'b0, 1'b0, 32'hFF, 4'h0, 32'h0, 32'hFFFFABCD};
        tbl[6]  = '{1'b1, 3'd2, 32'h10010024, 32'hCAFEF00D, 1'b0, 1'b1, 32'h00, 4'hF, 32'hCAFEF00D, 32'h0};
        tbl[7]  = '{1'b0, 3'd2, 32'h10010024, 32'h0,        1'b0, 1'b1, 32'h00, 4'h0, 32'h0, 32'hCAFEF00D};
        tbl[8]  = '{1'b0, 3'd2, 32'h10010002, 32'h0,        1'b1, 1'b0, 32'h00, 4'h0, 32'h0, 32'h0};
        tbl[9]  = '{1'b0, 3'd2, 32'h00000000, 32'h0,        1'b1, 1'b0, 32'h00, 4'h0, 32'h0, 32'h0};
        tbl[10] = '{1'b0, 3'd3, 32'h10010000, 32'h0,        1'b1, 1'b0, 32'h00, 4'h0, 32'h0, 32'h0};
        tbl[11] = '{1'b1, 3'd4, 32'h10010000, 32'h12345678, 1'b1, 1'b0, 32'h00, 4'h0, 32'h0, 32'h0};
        tbl[12] = '{1'b1, 3'd0, 32'h10010001, 32'h00000055, 1'b0, 1'b0, 32'h00, 4'h2, 32'h55555555, 32'h0};
        tbl[13] = '{1'b0, 3'd2, 32'h10010000, 32'h0,        1'b0, 1'b0, 32'h00, 4'h0, 32'h0, 32'h80FF5511};
        tbl[14] = '{1'b0, 3'd5, 32'h10010002, 32'h0,        1'b0, 1'b0, 32'h00, 4'h0, 32'h0, 32'h000080FF};
        tbl[15] = '{1'b0, 3'd2, 32'h10010200, 32'h0,        1'b1, 1'b0, 32'h00, 4'h0, 32'h0, 32'h0};
        tbl[16] = '{1'b1, 3'd2, 32'h10010034, 32'h01234567, 1'b0, 1'b0, 32'h0D, 4'hF, 32'h01234567, 32'h0};
        tbl[17] = '{1'b0, 3'd2, 32'h10010034, 32'h0,        1'b0, 1'b0, 32'h0D, 4'h0, 32'h0, 32'h01234567};
        tbl[18] = '{1'b1, 3'd2, 32'h7FFFEE00, 32'h89ABCDEF, 1'b0, 1'b0, 32'h80, 4'hF, 32'h89ABCDEF, 32'h0};
        tbl[19] = '{1'b1, 3'd2, 32'h7FFFEDFC, 32'h11111111, 1'b1, 1'b0, 32'h00, 4'h0, 32'h0, 32'h0};
        tbl[20] = '{1'b0, 3'd2, 32'h7FFFF000, 32'h0,        1'b1, 1'b0, 32'h00, 4'h0, 32'h0, 32'h0};
        tbl[21] = '{1'b1, 3'd1, 32'h10010031, 32'h0000BEEF, 1'b1, 1'b0, 32'h00, 4'h0, 32'h0, 32'h0};
        tbl[22] = '{1'b0, 3'd0, 32'h10010027, 32'h0,        1'b0, 1'b1, 32'h00, 4'h0, 32'h0, 32'hFFFFFFCA};

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = '0;
        req_addr   = '0;
        req_wdata  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset ready", 32'(req_ready), 32'd1);
        chk("reset rsp", 32'({rsp_valid, rsp_err}), 32'd0);
        chk("reset rdata", rsp_rdata, 32'd0);
        chk("reset en", 32'({dmem_en, mmio_en, dmem_we, mmio_we}), 32'd0);

        for (int i = 0; i < NV; i++) begin
            model(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, scratch);
            apply(tbl[i], $sformatf("tbl%0d", i));
        end

        for (int n = 0; n < 300; n++) begin
            bit [31:0] a;
            case ($urandom_range(0, 5))
                0:       a = A_DATA + $urandom_range(0, 63);
                1:       a = A_MMIO + $urandom_range(0, 15);
                2:       a = 32'h7FFF_EFC0 + $urandom_range(0, 67);
                3:       a = 32'h7FFF_EDF8 + $urandom_range(0, 15);
                4:       a = 32'h1001_01F0 + $urandom_range(0, 31);
                default: a = $urandom;
            endcase
            model(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, v);
            apply(v, $sformatf("rand%0d", n));
        end

        // Reset lands while a load is in its ACCESS cycle.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'd2;
        req_addr   = A_DATA;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst en_before", 32'(dmem_en), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst en_abort", 32'({dmem_en, mmio_en}), 32'd0);
        chk("rst rsp_abort", 32'(rsp_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("rst no_rsp", 32'(seen), 32'd0);
        chk("rst ready", 32'(req_ready), 32'd1);
        model(1'b0, 3'd2, A_DATA, 32'd0, v);
        apply(v, "post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
